// File: rtl/nexys_starship_fault_gen.sv
// rtl/nexys_starship_fault_gen.sv - fault scheduler for the four subsystem repair FSMs
//
// Ports:
//   Clk, Reset_n        : clock, asynchronous active-low reset
//   play_flag           : start of play, sampled only while idle
//   gameover_ctrl       : forces IDLE from any state, masks fault_pulse
//   broken[3:0]         : subsystem broken flags (0 top, 1 bottom, 2 left, 3 right)
//   fault_pulse[3:0]    : one-hot, one-cycle break request
//   fault_hex[3:0]      : repair combo, latched on entry to FIRE and held
//   level[2:0]          : difficulty level, 0..7
//   q_Idle..q_Fire      : one-hot state outputs
//
// Build option: FAULT_GEN_JITTER_EN adds lfsr[11:8] (saturating) to every COUNT load.

module nexys_starship_fault_gen #(
  parameter logic [15:0] BASE_INTERVAL = 16'd50000,
  parameter logic [15:0] MIN_INTERVAL  = 16'd2,
  parameter logic [7:0]  LEVEL_STEP    = 8'd4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       play_flag,
  input  logic       gameover_ctrl,
  input  logic [3:0] broken,
  output logic [3:0] fault_pulse,
  output logic [3:0] fault_hex,
  output logic [2:0] level,
  output logic       q_Idle,
  output logic       q_Count,
  output logic       q_Select,
  output logic       q_Fire
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_COUNT  = 4'b0010,
    S_SELECT = 4'b0100,
    S_FIRE   = 4'b1000
  } state_t;

  localparam logic [3:0] LAST_NONE = 4'hF;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_lfsr;
  logic [15:0] r_cnt;
  logic [3:0]  r_hex;
  logic [1:0]  r_target;
  logic [3:0]  r_last_target;
  logic [2:0]  r_level;
  logic [7:0]  r_fault_count;

  logic        w_lfsr_fb;
  logic [7:0]  w_count_inc;
  logic        w_level_step;
  logic [2:0]  w_level_fire;
  logic [7:0]  w_count_fire;
  logic [15:0] w_interval;
  logic [15:0] w_load;
  logic        w_found;
  logic [1:0]  w_pick;
  logic [1:0]  w_idx;

  function automatic logic [15:0] f_interval(input logic [2:0] lvl);
    logic [15:0] sh;
    sh = BASE_INTERVAL >> lvl;
    return (sh < MIN_INTERVAL) ? MIN_INTERVAL : sh;
  endfunction

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Level bookkeeping applied when a FIRE cycle completes.
  assign w_count_inc  = r_fault_count + 8'd1;
  assign w_level_step = (w_count_inc == LEVEL_STEP);
  assign w_count_fire = w_level_step ? 8'd0 : w_count_inc;
  assign w_level_fire = !w_level_step ? r_level :
                        (r_level == 3'd7) ? 3'd7 : r_level + 3'd1;

  // Leaving FIRE reloads with the interval of the level it is about to hold.
  assign w_interval = f_interval((r_state == S_FIRE) ? w_level_fire : r_level);

`ifdef FAULT_GEN_JITTER_EN
  logic [16:0] w_load_sum;
  assign w_load_sum = {1'b0, w_interval} + {13'd0, r_lfsr[11:8]};
  assign w_load     = w_load_sum[16] ? 16'hFFFF : w_load_sum[15:0];
`else
  assign w_load = w_interval;
`endif

  // Rotating scan from lfsr[1:0]; skips broken targets and the last one fired.
  always_comb begin
    w_found = 1'b0;
    w_pick  = 2'd0;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_lfsr[1:0] + 2'(k);
      if (!w_found && !broken[w_idx] && ({2'b00, w_idx} != r_last_target)) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (play_flag) w_next = S_COUNT;
      S_COUNT:  if (r_cnt == 16'd1) w_next = S_SELECT;
      S_SELECT: if (w_found) w_next = S_FIRE;
      S_FIRE:   w_next = S_COUNT;
      default:  w_next = S_IDLE;
    endcase
    if (gameover_ctrl) w_next = S_IDLE;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= S_IDLE;
      r_lfsr        <= LFSR_SEED;
      r_cnt         <= 16'd0;
      r_hex         <= 4'd0;
      r_target      <= 2'd0;
      r_last_target <= LAST_NONE;
      r_level       <= 3'd0;
      r_fault_count <= 8'd0;
    end else begin
      r_state <= w_next;
      r_lfsr  <= {w_lfsr_fb, r_lfsr[15:1]};

      if (w_next == S_IDLE) begin
        r_level       <= 3'd0;
        r_fault_count <= 8'd0;
      end else if (r_state == S_FIRE) begin
        r_level       <= w_level_fire;
        r_fault_count <= w_count_fire;
      end

      if (w_next == S_COUNT && r_state != S_COUNT) begin
        r_cnt <= w_load;
      end else if (r_state == S_COUNT) begin
        r_cnt <= r_cnt - 16'd1;
      end

      if (r_state == S_SELECT && w_next == S_FIRE) begin
        r_target <= w_pick;
        r_hex    <= r_lfsr[7:4];
      end

      // A fired target stays excluded until its broken flag is seen high.
      if (r_state == S_FIRE && !gameover_ctrl) begin
        r_last_target <= {2'b00, r_target};
      end else if (r_last_target != LAST_NONE && broken[r_last_target[1:0]]) begin
        r_last_target <= LAST_NONE;
      end
    end
  end

  assign fault_pulse = (r_state == S_FIRE && !gameover_ctrl) ? (4'b0001 << r_target) : 4'b0000;
  assign fault_hex   = r_hex;
  assign level       = r_level;
  assign q_Idle      = r_state[0];
  assign q_Count     = r_state[1];
  assign q_Select    = r_state[2];
  assign q_Fire      = r_state[3];

endmodule

// File: tb/tb_nexys_starship_fault_gen.sv
// tb/tb_nexys_starship_fault_gen.sv - scoreboard bench for nexys_starship_fault_gen

module tb_nexys_starship_fault_gen;

  logic       Clk;
  logic       Reset_n;
  logic       play_flag;
  logic       gameover_ctrl;
  logic [3:0] broken;
  logic [3:0] fault_pulse;
  logic [3:0] fault_hex;
  logic [2:0] level;
  logic       q_Idle, q_Count, q_Select, q_Fire;

  logic [3:0]  stim_broken;
  logic [3:0]  model_broken;
  logic        model_en;
  logic        norep_en;
  logic [15:0] lfsr_m;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
    int         lvl;
  } exp_t;
  exp_t q[$];

  assign broken = model_en ? model_broken : stim_broken;

  nexys_starship_fault_gen #(
    .BASE_INTERVAL(16'd8),
    .MIN_INTERVAL (16'd2),
    .LEVEL_STEP   (8'd2),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .play_flag    (play_flag),
    .gameover_ctrl(gameover_ctrl),
    .broken       (broken),
    .fault_pulse  (fault_pulse),
    .fault_hex    (fault_hex),
    .level        (level),
    .q_Idle       (q_Idle),
    .q_Count      (q_Count),
    .q_Select     (q_Select),
    .q_Fire       (q_Fire)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, seed ACE1, shifting every cycle.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) lfsr_m <= 16'hACE1;
    else          lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  // Pulse monitor: pops the scoreboard and checks target choice and combo
  // against the SELECT-cycle LFSR, broken flags and last-target rule.
  task automatic monitor();
    logic [15:0] lp;
    logic [3:0]  bp, exp_p, b_last, last_prev, last_pulse;
    logic [1:0]  idx;
    logic        found;
    int          norep_cnt;
    exp_t        e;
    lp = '0; bp = '0; b_last = 4'hF; last_prev = 4'hF; last_pulse = '0; norep_cnt = 0;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        b_last    = 4'hF;
        last_prev = 4'hF;
      end else begin
        if (fault_pulse !== 4'b0000) begin
          exp_p = 4'b0000;
          found = 1'b0;
          for (int k = 0; k < 4; k++) begin
            idx = 2'(lp[1:0] + 2'(k));
            if (!found && !bp[idx] && ({2'b00, idx} != last_prev)) begin
              found = 1'b1;
              exp_p = 4'b0001 << idx;
            end
          end
          if (q.size() == 0) begin
            chk("unexpected_pulse", 32'(fault_pulse), 32'(4'b0000));
          end else begin
            e = q.pop_front();
            chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
            if (e.mask != 4'b0000) chk("pulse_bits", 32'(fault_pulse), 32'(e.mask));
            if (e.lvl >= 0) chk("pulse_level", 32'(level), 32'(e.lvl));
          end
          chk("pulse_onehot", 32'($onehot(fault_pulse)), 32'd1);
          chk("pulse_target", 32'(fault_pulse), 32'(exp_p));
          chk("pulse_hex", 32'(fault_hex), 32'(lp[7:4]));
          if (norep_en) begin
            if (norep_cnt > 0) chk("no_repeat", 32'(fault_pulse != last_pulse), 32'd1);
            norep_cnt++;
            last_pulse = fault_pulse;
          end
        end else if (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          chk("missing_pulse", 32'(cyc), 32'(e.cyc));
        end
        last_prev = b_last;
        if (fault_pulse !== 4'b0000) begin
          for (int k = 0; k < 4; k++) if (fault_pulse[k] === 1'b1) b_last = 4'(k);
        end else if (b_last != 4'hF && broken[b_last[1:0]]) begin
          b_last = 4'hF;
        end
      end
      if (!norep_en) norep_cnt = 0;
      lp = lfsr_m;
      bp = broken;
    end
  endtask

  // Subsystem model: flag rises 1 cycle after its pulse, drops 3 cycles later.
  task automatic bmodel();
    int set_at[4];
    int clr_at[4];
    for (int k = 0; k < 4; k++) begin
      set_at[k] = -100;
      clr_at[k] = -100;
    end
    forever begin
      @(posedge Clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (cyc == set_at[k]) model_broken[k] = 1'b1;
        if (cyc == clr_at[k]) model_broken[k] = 1'b0;
      end
      @(negedge Clk);
      for (int k = 0; k < 4; k++) begin
        if (fault_pulse[k] === 1'b1) begin
          set_at[k] = cyc + 1;
          clr_at[k] = cyc + 4;
        end
      end
    end
  endtask

  initial begin
    int c, d, e0, base;
    Reset_n       = 1'b0;
    play_flag     = 1'b0;
    gameover_ctrl = 1'b0;
    stim_broken   = 4'b0000;
    model_broken  = 4'b0000;
    model_en      = 1'b0;
    norep_en      = 1'b0;
    fork
      monitor();
      bmodel();
    join_none

    // Reset state
    repeat (3) tick();
    chk("rst_q_idle", 32'(q_Idle), 32'd1);
    chk("rst_q_count", 32'(q_Count), 32'd0);
    chk("rst_q_select", 32'(q_Select), 32'd0);
    chk("rst_q_fire", 32'(q_Fire), 32'd0);
    chk("rst_pulse", 32'(fault_pulse), 32'd0);
    chk("rst_hex", 32'(fault_hex), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    Reset_n = 1'b1;
    tick();
    tick();

    // First pulse and level ramp with the broken-flag model
    model_en = 1'b1;
    c = cyc;
    play_flag = 1'b1;
    q.push_back('{c + 10, 4'b0000, 0});
    q.push_back('{c + 20, 4'b0000, 0});
    q.push_back('{c + 26, 4'b0000, 1});
    q.push_back('{c + 32, 4'b0000, 1});
    q.push_back('{c + 36, 4'b0000, 2});
    q.push_back('{c + 40, 4'b0000, 2});
    q.push_back('{c + 44, 4'b0000, 3});
    tick();
    play_flag = 1'b0;
    chk("play_to_count", 32'(q_Count), 32'd1);
    wait_cyc(c + 45);
    chk("level_ramp", 32'(level), 32'd3);

    // Game over asserted during FIRE
    wait_cyc(c + 48);
    chk("go_in_fire", 32'(q_Fire), 32'd1);
    gameover_ctrl = 1'b1;
    #1;
    chk("go_pulse_masked", 32'(fault_pulse), 32'd0);
    tick();
    chk("go_idle", 32'(q_Idle), 32'd1);
    chk("go_level", 32'(level), 32'd0);
    gameover_ctrl = 1'b0;

    // Restart at level 0 with broken held low: no-repeat rule
    model_en = 1'b0;
    norep_en = 1'b1;
    d = cyc;
    play_flag = 1'b1;
    q.push_back('{d + 10, 4'b0000, 0});
    q.push_back('{d + 20, 4'b0000, 0});
    q.push_back('{d + 26, 4'b0000, 1});
    q.push_back('{d + 32, 4'b0000, 1});
    q.push_back('{d + 36, 4'b0000, 2});
    q.push_back('{d + 40, 4'b0000, 2});
    tick();
    play_flag = 1'b0;
    wait_cyc(d + 41);
    norep_en = 1'b0;

    // broken=1110 with last target cleared: pulse lands on bit 0
    for (int k = 0; k < 3; k++) begin
      base = d + 40 + 4 * k;
      q.push_back('{base + 4, 4'b0001, -1});
      wait_cyc(base + 1);
      stim_broken = 4'b1111;
      wait_cyc(base + 2);
      stim_broken = 4'b1110;
    end

    // All broken: SELECT holds; freeing bit 2 fires it next cycle
    wait_cyc(d + 53);
    stim_broken = 4'b1111;
    wait_cyc(d + 60);
    chk("hold_select", 32'(q_Select), 32'd1);
    chk("hold_no_pulse", 32'(fault_pulse), 32'd0);
    stim_broken = 4'b1011;
    q.push_back('{d + 61, 4'b0100, -1});

    // Asynchronous reset in the middle of COUNT
    wait_cyc(d + 62);
    chk("pre_rst_count", 32'(q_Count), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_q_idle", 32'(q_Idle), 32'd1);
    chk("arst_q_count", 32'(q_Count), 32'd0);
    chk("arst_pulse", 32'(fault_pulse), 32'd0);
    chk("arst_hex", 32'(fault_hex), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    tick();
    Reset_n = 1'b1;
    stim_broken = 4'b0000;

    // Fresh start after reset: level-0 interval and reseeded LFSR
    e0 = cyc;
    play_flag = 1'b1;
    q.push_back('{e0 + 10, 4'b0000, 0});
    tick();
    play_flag = 1'b0;
    wait_cyc(e0 + 12);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
